// File: rtl/rr_arbiter4_pkg.sv
// ----------------------------------------------------------------------------
// rr_arbiter4_pkg
// Shared definitions for the four-requester round-robin arbiter:
//   - arb_state_e : arbiter state encoding (ARB_IDLE / ARB_GRANT)
//   - ARB_NUM_REQ : number of requesters
//   - win_t       : result of a round-robin winner search
//   - find_winner : rotating-priority search used by the arbiter
// ----------------------------------------------------------------------------
package rr_arbiter4_pkg;

    localparam int ARB_NUM_REQ = 4;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } win_t;

    // Return the first set request scanning start, start+1, ... modulo 4.
    // Iterating from the farthest offset down lets the nearest hit overwrite
    // earlier ones, so the closest requester to start wins.
    function automatic win_t find_winner(input logic [3:0] req, input logic [1:0] start);
        win_t       res;
        logic [1:0] off;
        logic [1:0] idx;
        res.found = 1'b0;
        res.idx   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            off = 2'(k);
            idx = start + off;
            if (req[idx]) begin
                res.found = 1'b1;
                res.idx   = idx;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter4_grant_decoder.sv
// ----------------------------------------------------------------------------
// grant_decoder
// Structural 2-to-4 decoder with enable, built from NOT and AND primitives.
// Ports:
//   out0..out3 : decoded one-hot outputs (all zero when enable is low)
//   address0   : address bit 0
//   address1   : address bit 1
//   enable     : global output enable
// ----------------------------------------------------------------------------
module grant_decoder (
    output logic out0,
    output logic out1,
    output logic out2,
    output logic out3,
    input  logic address0,
    input  logic address1,
    input  logic enable
);

    logic address0_n_s;
    logic address1_n_s;

    not u_inv0 (address0_n_s, address0);
    not u_inv1 (address1_n_s, address1);

    and u_and0 (out0, address0_n_s, address1_n_s, enable);
    and u_and1 (out1, address0,     address1_n_s, enable);
    and u_and2 (out2, address0_n_s, address1,     enable);
    and u_and3 (out3, address0,     address1,     enable);

endmodule

// File: rtl/rr_arbiter4.sv
// ----------------------------------------------------------------------------
// rr_arbiter4
// Four-requester round-robin arbiter with bounded hold time. The winning
// requester index and enable are registered and decoded into one-hot grants.
// Parameters:
//   MAX_HOLD : max consecutive grant cycles while another requester waits (>=2)
//   CNT_W    : hold counter width, 2**CNT_W >= MAX_HOLD
// Ports:
//   clk          : clock, rising edge
//   reset        : asynchronous active-high reset
//   req[3:0]     : level-sensitive request per requester
//   grant[3:0]   : one-hot grant, zero when idle
//   grantAddress : registered index of granted requester
//   grantEnable  : registered, high while a grant is active
//   holdCount    : registered cycles elapsed in the current grant (saturating)
// ----------------------------------------------------------------------------
module rr_arbiter4
    import rr_arbiter4_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    output logic [3:0]       grant,
    output logic [1:0]       grantAddress,
    output logic             grantEnable,
    output logic [CNT_W-1:0] holdCount
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    arb_state_e       state_r, state_s;
    logic [1:0]       ptr_r, ptr_s;
    logic [1:0]       addr_r, addr_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;

    logic [3:0]       holder_mask_s;
    logic [3:0]       others_s;
    logic             release_s;
    win_t             win_idle_s;
    win_t             win_next_s;

    // Competitor view and the two winner searches (from ptr, and from holder+1).
    always_comb begin
        holder_mask_s = 4'b0001 << addr_r;
        others_s      = req & ~holder_mask_s;
        // The holder is excluded from the hand-off search so that a release
        // always moves the grant away even if the holder re-requests.
        win_idle_s    = find_winner(req, ptr_r);
        win_next_s    = find_winner(others_s, addr_r + 2'd1);
        release_s     = ~req[addr_r] | ((cnt_r == HOLD_LAST) & (others_s != 4'b0000));
    end

    // Next-state, pointer, grant address and hold counter.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        addr_s  = addr_r;
        cnt_s   = cnt_r;
        case (state_r)
            ARB_IDLE: begin
                if (win_idle_s.found) begin
                    addr_s  = win_idle_s.idx;
                    cnt_s   = CNT_ZERO;
                    state_s = ARB_GRANT;
                end else begin
                    cnt_s   = CNT_ZERO;
                end
            end
            ARB_GRANT: begin
                if (release_s) begin
                    ptr_s = addr_r + 2'd1;
                    cnt_s = CNT_ZERO;
                    if (win_next_s.found) begin
                        addr_s  = win_next_s.idx;
                        state_s = ARB_GRANT;
                    end else begin
                        state_s = ARB_IDLE;
                    end
                end else begin
                    if (cnt_r != HOLD_LAST) begin
                        cnt_s = cnt_r + CNT_ONE;
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
            end
            default: begin
                state_s = ARB_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // State and datapath registers; reset drops the grant immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ARB_IDLE;
            ptr_r   <= 2'd0;
            addr_r  <= 2'd0;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            addr_r  <= addr_s;
            cnt_r   <= cnt_s;
        end
    end

    assign grantAddress = addr_r;
    assign grantEnable  = (state_r == ARB_GRANT);
    assign holdCount    = cnt_r;

    grant_decoder u_grant_decoder (
        .out0     (grant[0]),
        .out1     (grant[1]),
        .out2     (grant[2]),
        .out3     (grant[3]),
        .address0 (addr_r[0]),
        .address1 (addr_r[1]),
        .enable   (grantEnable)
    );

endmodule
